// File: rtl/vga_pkg.sv
// Shared constants, RGB332 field slices and FSM states for the VGA line fetcher.
// Used by vga_line_fetch (optional VGA_LINE_FETCH_DOUBLE_SCAN_EN) and its FIFO.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int LINE_W    = $clog2(V_VISIBLE);

  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 4;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/vga_line_fetch_if.sv
// Framebuffer read bus: in-order request/return with a ready stall.
// master = line fetcher, slave = memory.
interface vga_line_fetch_if #(
  parameter int ADDR_W = 19
) ();

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/vga_pixel_fifo.sv
// Synchronous pixel FIFO with flush; head word visible on dout.
// Caller guarantees no push when full and no pop when empty.
module vga_pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Streams one scan line of RGB332 pixels into a FIFO and expands to RGB888.
// Option macro VGA_LINE_FETCH_DOUBLE_SCAN_EN: 320x240 source, each pixel shown twice.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int H_PIXELS        = H_VISIBLE,
  parameter int ADDR_W          = 19,
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [LINE_W-1:0] line_y,
  input  logic              pix_req,
  vga_line_fetch_if.master  mem,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              underflow,
  input  logic              underflow_clr
);

  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [LINE_W-1:0] src_y;

`ifdef VGA_LINE_FETCH_DOUBLE_SCAN_EN
  localparam int WORDS = H_PIXELS / 2;
  assign src_y = line_y >> 1;
`else
  localparam int WORDS = H_PIXELS;
  assign src_y = line_y;
`endif

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] base_nxt;
  logic [OUT_W-1:0]  outst;
  logic [OUT_W-1:0]  outst_nxt;
  logic [OUT_W-1:0]  discard;
  logic [CNT_W-1:0]  fcount;
  logic              fempty;
  logic [7:0]        fdout;
  logic              room;
  logic              rd;
  logic              acc;
  logic              push;
  logic              fpop;
  logic [2:0]        r3;
  logic [2:0]        g3;
  logic [1:0]        b2;

  assign base_nxt = ADDR_W'(src_y) * ADDR_W'(WORDS);

  // Reservation counts in-flight reads so returns always find a free slot.
  assign room = (int'(fcount) + int'(outst) < FIFO_DEPTH)
             && (int'(outst) < MAX_OUTSTANDING);

  assign rd   = (state == FETCH) && (discard == '0)
             && (col != COL_W'(WORDS)) && room;
  assign acc  = rd && mem.mem_ready;
  assign push = mem.mem_rvalid && (discard == '0) && !line_start;

  assign mem.mem_rd   = rd;
  assign mem.mem_addr = base + ADDR_W'(col);

  always_comb begin
    outst_nxt = outst;
    if (acc && !mem.mem_rvalid) begin
      outst_nxt = outst + OUT_W'(1);
    end else if (!acc && mem.mem_rvalid) begin
      outst_nxt = outst - OUT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      col   <= '0;
      base  <= '0;
    end else if (line_start) begin
      state <= FETCH;
      col   <= '0;
      base  <= base_nxt;
    end else begin
      if (acc) begin
        col <= col + COL_W'(1);
      end
      unique case (state)
        IDLE:  state <= IDLE;
        FETCH: if (col == COL_W'(WORDS)) state <= DRAIN;
        DRAIN: if (outst == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Returns of the abandoned line are counted off here, never enqueued.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      outst   <= '0;
      discard <= '0;
    end else begin
      outst <= outst_nxt;
      if (line_start) begin
        discard <= outst_nxt;
      end else if (mem.mem_rvalid && discard != '0) begin
        discard <= discard - OUT_W'(1);
      end
    end
  end

`ifdef VGA_LINE_FETCH_DOUBLE_SCAN_EN
  logic half;

  assign fpop = pix_req && !fempty && half;

  always_ff @(posedge clock) begin
    if (!reset_n || line_start) begin
      half <= 1'b0;
    end else if (pix_req && !fempty) begin
      half <= !half;
    end
  end
`else
  assign fpop = pix_req && !fempty;
`endif

  vga_pixel_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (line_start),
    .push    (push),
    .din     (mem.mem_rdata),
    .pop     (fpop),
    .dout    (fdout),
    .count   (fcount),
    .empty   (fempty)
  );

  assign r3 = fdout[R_HI:R_LO];
  assign g3 = fdout[G_HI:G_LO];
  assign b2 = fdout[B_HI:B_LO];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      underflow <= 1'b0;
    end else begin
      if (pix_req) begin
        if (!fempty) begin
          red   <= {r3, r3, r3[2:1]};
          green <= {g3, g3, g3[2:1]};
          blue  <= {b2, b2, b2, b2};
        end else begin
          red   <= '0;
          green <= '0;
          blue  <= '0;
        end
      end
      underflow <= (pix_req && fempty) || (underflow && !underflow_clr);
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Randomized scoreboard bench for vga_line_fetch with an in-order
// variable-latency memory model and a queue-level pixel reference.
module tb_vga_line_fetch;

`ifdef VGA_LINE_FETCH_DOUBLE_SCAN_EN
  localparam int WORDS = 320;
  localparam bit DS = 1'b1;
`else
  localparam int WORDS = 640;
  localparam bit DS = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] line_y = '0;
  logic       pix_req = 1'b0;
  logic       underflow_clr = 1'b0;
  logic [7:0] red, green, blue;
  logic       underflow;

  vga_line_fetch_if #(.ADDR_W(19)) mem ();

  vga_line_fetch dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .line_start    (line_start),
    .line_y        (line_y),
    .pix_req       (pix_req),
    .mem           (mem),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    int         due;
    logic [7:0] data;
    int         gen;
  } rd_t;

  rd_t         pipe[$];
  logic [7:0]  q[$];
  logic [23:0] sb[$];
  logic [7:0]  pat [4] = '{8'hE0, 8'h1C, 8'h03, 8'hFF};

  int          cyc = 0;
  int          gen = 0;
  int          exp_idx = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [18:0] exp_base = '0;
  logic [18:0] pat_base = '0;
  bit          active = 1'b0;
  bit          uf = 1'b0;
  bit          pend = 1'b0;
  bit          prev_rst = 1'b0;
  bit          seen_rst = 1'b0;
  logic [18:0] pend_addr = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mdata(input logic [18:0] a);
    if (a >= pat_base && a < pat_base + 19'd4)
      return pat[int'(a - pat_base)];
    return a[7:0] ^ a[15:8] ^ {a[18:16], 5'd0};
  endfunction

  function automatic logic [23:0] expand(input logic [7:0] p);
    logic [2:0] r, g;
    logic [1:0] b;
    r = p[7:5];
    g = p[4:2];
    b = p[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  function automatic logic [18:0] line_base(input logic [8:0] y);
    if (DS) return 19'(y >> 1) * 19'd320;
    return 19'(y) * 19'd640;
  endfunction

  task automatic step(input bit rst, input bit ls, input logic [8:0] ly,
                      input bit pr, input bit rdy, input bit clr,
                      input int lat);
    rd_t         ret;
    bit          rv;
    bit          mrd;
    bit          set;
    int          ent;
    logic [18:0] maddr;
    @(negedge clock);
    reset_n       = !rst;
    line_start    = ls;
    line_y        = ly;
    pix_req       = pr;
    underflow_clr = clr;
    mem.mem_ready = rdy;
    rv = 1'b0;
    if (!rst && pipe.size() > 0 && pipe[0].due <= cyc) begin
      ret = pipe.pop_front();
      rv  = 1'b1;
    end
    mem.mem_rvalid = rv;
    mem.mem_rdata  = rv ? ret.data : 8'h00;
    #1;
    mrd   = mem.mem_rd;
    maddr = mem.mem_addr;
    if (prev_rst && !rst) begin
      check("rst_mem_rd", 32'(mrd), 0);
      check("rst_rgb", {8'h0, red, green, blue}, 0);
      check("rst_underflow", 32'(underflow), 0);
      if (cyc < 10) check("rst_mem_addr", 32'(maddr), 0);
    end
    if (seen_rst && !rst) check("underflow", 32'(underflow), 32'(uf));
    if (pend && !rst) begin
      check("hold_rd", 32'(mrd), 1);
      check("hold_addr", 32'(maddr), 32'(pend_addr));
    end
    pend      = !rst && !ls && mrd && !rdy;
    pend_addr = maddr;
    if (rst) begin
      pipe.delete();
      q.delete();
      uf       = 1'b0;
      active   = 1'b0;
      gen++;
      pend     = 1'b0;
      seen_rst = 1'b1;
    end else begin
      if (mrd && rdy) begin
        if (!active || exp_idx >= WORDS) begin
          check("rd_allowed", 32'(mrd), 0);
        end else begin
          check("rd_addr", 32'(maddr), 32'(exp_base) + 32'(exp_idx));
          exp_idx++;
        end
        pipe.push_back(rd_t'{cyc + lat, mdata(maddr), gen});
      end
      set = 1'b0;
      if (pr) begin
        if (q.size() > 0) begin
          sb.push_back(expand(q.pop_front()));
        end else begin
          sb.push_back(24'h0);
          set = 1'b1;
        end
      end
      uf = set ? 1'b1 : (clr ? 1'b0 : uf);
      if (rv && ret.gen == gen && !ls) begin
        q.push_back(ret.data);
        if (DS) q.push_back(ret.data);
      end
      if (ls) begin
        q.delete();
        gen++;
        exp_base = line_base(ly);
        exp_idx  = 0;
        active   = 1'b1;
      end
      ent = DS ? (q.size() + 1) / 2 : q.size();
      check("outstanding_le4", 32'(pipe.size() <= 4), 1);
      check("reserve_le16", 32'(ent + pipe.size() <= 16), 1);
    end
    prev_rst = rst;
    cyc++;
  endtask

  initial begin : monitor
    bit          fired;
    logic [23:0] e;
    forever begin
      @(posedge clock);
      fired = pix_req && reset_n;
      #1;
      if (fired) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rgb_extra: got %0h expected none", {red, green, blue});
        end else begin
          e = sb.pop_front();
          check("rgb", {8'h0, red, green, blue}, {8'h0, e});
        end
      end
    end
  end

  initial begin : stim
    bit          ls, pr, rst;
    logic [18:0] b2;
    mem.mem_ready  = 1'b0;
    mem.mem_rvalid = 1'b0;
    mem.mem_rdata  = '0;
    pat_base = 19'h7FFF0;
    repeat (3) step(1, 0, 0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1, 1);
    repeat (2) step(0, 0, 0, 0, 1, 0, 1);

    b2 = line_base(9'd2);
    pat_base = b2;
    step(0, 1, 9'd2, 0, 1, 0, 1);
    repeat (30) step(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3000 &&
         (exp_idx < WORDS || q.size() > 0 || pipe.size() > 0); i++) begin
      step(0, 0, 0, q.size() > 0, 1, 0, 1);
    end
    check("line_reads", 32'(exp_idx), 32'(WORDS));
    check("line_no_underflow", 32'(underflow), 0);

    for (int i = 0; i < 8000; i++) begin
      rst = (i == 4000 || i == 4001);
      if (rst) ls = 1'b0;
      else if (!active) ls = ($urandom % 8 == 0) && i > 4010;
      else if (exp_idx >= WORDS) ls = ($urandom % 20 == 0);
      else ls = ($urandom % 400 == 0);
      if (i < 4000 && !active) ls = ($urandom % 8 == 0);
      pr = !rst && ($urandom % 3 != 0);
      step(rst, ls, 9'($urandom_range(0, 479)), pr, $urandom % 4 != 0,
           $urandom % 40 == 0, $urandom_range(1, 6));
    end
    repeat (3) step(0, 0, 0, 0, 1, 0, 1);
    check("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
- Upstream pixel source for the VGA timing controller: streams one scan line of RGB332 pixels from framebuffer memory into a small FIFO ahead of display.
- On each pixel request from the controller, returns expanded 24-bit RGB.
- Decouples variable memory read latency from the fixed 25 MHz pixel cadence; flags underflow when memory cannot keep up.

Parameters:
- H_PIXELS, 640, visible pixels per line (columns fetched per line_start).
- ADDR_W, 19, framebuffer word-address width (640*480 = 307200 < 2^19).
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, >= 4.
- MAX_OUTSTANDING, 4, max reads issued but not yet returned.

Ports:
- clock  in  1  system clock (50 MHz domain; pixel cadence set by pix_req).
- reset_n  in  1  synchronous active-low reset.
- line_start  in  1  one-cycle pulse: begin fetching line line_y; sampled in any state.
- line_y  in  9  line index 0..479, valid with line_start.
- pix_req  in  1  controller consumes one pixel this cycle.
- mem_rd  out  1  read request, one cycle per word.
- mem_addr  out  ADDR_W  read address, valid with mem_rd.
- mem_ready  in  1  memory accepts mem_rd this cycle.
- mem_rvalid  in  1  read data valid; returns arrive in issue order.
- mem_rdata  in  8  RGB332 pixel {r[2:0],g[2:0],b[1:0]}.
- red, green, blue  out  8 each  expanded pixel.
- underflow  out  1  sticky: pix_req seen with FIFO empty.
- underflow_clr  in  1  clears underflow.

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; mem_rd=0; mem_addr=0; red/green/blue=0; underflow=0; FIFO empty; column and outstanding counters 0.
- FSM: IDLE -> FETCH on line_start. FETCH -> DRAIN when column == H_PIXELS. DRAIN -> IDLE when outstanding == 0. line_start in any state -> FETCH (restart).
- Address: mem_addr = line_y*H_PIXELS + column, computed at ADDR_W bits; line base registered at line_start.
- Issue rule: in FETCH, assert mem_rd when (fifo_count + outstanding) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING. A read is issued only when mem_rd && mem_ready; column then increments. mem_rd/mem_addr are held stable until accepted.
- Outstanding count: +1 on accepted read, -1 on mem_rvalid; both in the same cycle -> unchanged.
- Returns: mem_rvalid pushes mem_rdata into the FIFO. The reservation rule guarantees the FIFO never overflows.
- Pop: pix_req with FIFO non-empty pops. red/green/blue update on the next clock (1-cycle latency) and hold until the next pop.
- Expansion by bit replication:
  - red = {r,r,r[2:1]}
  - green = {g,g,g[2:1]}
  - blue = {b,b,b,b}
  - 332 value 0xFF -> FF/FF/FF.
- Underflow: pix_req with FIFO empty -> outputs 0 next cycle and underflow sets. If underflow_clr and a new underflow occur in the same cycle, set wins.
- Same-cycle push and pop: fifo_count is unchanged. A pop from a FIFO that is empty that cycle is an underflow, with no bypass.
- Restart mid-line (line_start while in FETCH or DRAIN):
  - FIFO flushed; column = 0.
  - Returns still in flight (current outstanding count) are loaded into a discard counter and dropped as they arrive.
  - New reads are issued only after the discard counter reaches 0.
- pix_req outside FETCH/DRAIN with data present pops normally; stale pixels beyond H_PIXELS are not fetched.

Optional Feature:
- Macro VGA_LINE_FETCH_DOUBLE_SCAN_EN.
- Defined:
  - Framebuffer is 320x240; address = (line_y>>1)*(H_PIXELS/2) + column.
  - H_PIXELS/2 words fetched per line.
  - Each FIFO entry is emitted for two consecutive pix_req pops (a toggle bit holds the head entry).
- Undefined: 1:1 mapping as above.

Decomposition:
- Shared package vga_pkg: H_VISIBLE=640, V_VISIBLE=480, RGB332 field-slice constants, FSM state enum {IDLE, FETCH, DRAIN}.
- Sub-module vga_pixel_fifo: synchronous FIFO with push/pop/count/empty, width 8, depth FIFO_DEPTH.
- Expansion logic stays inline.

Test Plan:
- Zero-latency memory, line_start with line_y=2 -> first mem_addr = 1280; 640 reads accepted, addresses 1280..1919; no underflow.
- mem_rdata sequence 0xE0, 0x1C, 0x03, 0xFF, pix_req each cycle -> RGB FF/00/00, 00/FF/00, 00/00/FF, FF/FF/FF, each one cycle after its pop.
- Memory latency 6 cycles with mem_ready stalls -> outstanding never exceeds 4, fifo_count + outstanding never exceeds 16, mem_addr holds while mem_ready=0.
- pix_req issued before the first return -> RGB 000000; underflow=1 stays set until underflow_clr, then 0.
- line_start at column 100 with 3 reads outstanding -> those 3 returns are discarded, FIFO empty, next mem_addr = new line base.
- reset_n=0 mid-FETCH -> next cycle mem_rd=0, RGB 0, state IDLE; no further reads until line_start.
